ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, power of two, 2..16: instruction queue entries, which is also the credit limit.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port pc_in, input, 32: current fetch PC from the PC register.
REQ-005 SHALL have port stall_out, output, 1: 1 = PC register holds.
REQ-006 SHALL have port redirect_valid, input, 1: branch/jump redirect, same signal the PC register consumes.
REQ-007 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_req_addr (output, 32): instruction memory request channel.
REQ-008 SHALL have ports imem_rsp_valid (input, 1) and imem_rsp_data (input, 32): in-order responses, no backpressure.
REQ-009 SHALL have ports dec_valid (output, 1), dec_ready (input, 1), dec_instr (output, 32), dec_pc (output, 32) and dec_exc (output, 1): decode channel.

Function
REQ-010 SHALL define request fire = imem_req_valid && imem_req_ready and decode fire = dec_valid && dec_ready.
REQ-011 SHALL drive imem_req_valid = !redirect_valid && (count + outstanding) < QDEPTH, with imem_req_addr = pc_in.
REQ-012 SHALL drive stall_out = !(request fire) && !redirect_valid, so the PC advances exactly once per accepted request and a redirect is never masked by stall.
REQ-013 SHALL push pc_in into a PC tag FIFO on request fire; outstanding = requests issued minus responses retired.
REQ-014 SHALL pair each non-dropped response with the head tag, write {instr, pc, exc} into the queue, and reach dec_valid on the next cycle (1-cycle response-to-decode latency).
REQ-015 SHALL make the queue FIFO-ordered: dec_valid = count != 0, head held stable while dec_valid && !dec_ready.
REQ-016 SHALL allow simultaneous push and pop; count stays unchanged and the pointers wrap modulo QDEPTH.
REQ-017 SHALL, on redirect_valid, clear the queue and tag FIFO at the next edge, set drop_cnt = outstanding minus any response retiring that cycle, and discard the next drop_cnt responses without writing them.
REQ-018 SHALL allow new requests the cycle after a redirect even while drop_cnt != 0; discarded responses still free credits.
REQ-019 SHALL, if dec fire coincides with redirect, complete the handshake and still flush.
REQ-020 SHALL keep counter widths at clog2(QDEPTH)+1 with no overflow, since count + outstanding <= QDEPTH.

Reset
REQ-021 SHALL, on rst low, immediately clear the queue, tag FIFO, count, outstanding and drop_cnt.
REQ-022 SHALL hold imem_req_valid=0, dec_valid=0, stall_out=1, dec_instr=0, dec_pc=0 and dec_exc=0 while in reset.
REQ-023 SHALL, after reset release, ignore responses arriving for requests issued before reset, which the memory side also resets.

Configuration
REQ-024 SHALL, with IFETCH_MISALIGN_EN defined and pc_in[1:0] != 0, not assert imem_req_valid, instead push an entry with dec_exc=1, dec_instr=0 and dec_pc=pc_in when queue space exists, and deassert stall_out for that cycle.
REQ-025 SHALL, without IFETCH_MISALIGN_EN, drive imem_req_addr = {pc_in[31:2], 2'b00} and tie dec_exc to 0.

Structure
REQ-026 SHALL place the fetch entry struct {instr, pc, exc}, ILEN=32 and RESET_PC=32'h0 in the shared package aquila_pkg.
REQ-027 SHALL put queue storage in one parameterised sub-module ifetch_fifo, instantiated twice: entry queue and tag FIFO.

Verification
REQ-028 SHALL cover: reset, then memory always ready with 1-cycle response and dec_ready=1, pc_in from 0 -> decode sees pc 0,4,8,C back-to-back, stall_out=0 every cycle.
REQ-029 SHALL cover: dec_ready=0 with QDEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0 and stall_out=1 until one pop.
REQ-030 SHALL cover: redirect to 0x100 with 2 requests outstanding -> both responses dropped, first decoded pc is 0x100, queue is empty the cycle after the redirect.
REQ-031 SHALL cover: redirect while imem_req_ready=0 -> stall_out=0 that cycle, no request issued, next request address is 0x100.
REQ-032 SHALL cover: rst asserted with 3 queued entries and 1 outstanding -> dec_valid=0 immediately, no stale instruction after release.
REQ-033 SHALL cover: with IFETCH_MISALIGN_EN, pc_in=0x102 -> no memory request, decode gets dec_exc=1 and dec_pc=0x102; without the macro, request address is 0x100.

Source files
------------

// File: rtl/aquila_pkg.sv
// Shared definitions for the aquila core.
// Fetch entry layout and reset constants.
package aquila_pkg;

  localparam int ILEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
    logic            exc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small power-of-two FIFO used for fetch entries and PC tags.
// Synchronous clear has priority over push/pop.
module ifetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; reads are gated by count.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch control: credit-limited imem requests, tagged queue to decode.
// IFETCH_MISALIGN_EN turns misaligned PCs into exception entries.
module ifetch_ctrl
  import aquila_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        stall_out,
  input  logic        redirect_valid,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_exc
);

`ifdef IFETCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [CW-1:0] q_count;
  logic [CW-1:0] t_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   used;
  logic          credit;
  logic          mis;
  logic          req_fire;
  logic          dec_fire;
  logic          exc_push;
  logic          rsp_ret;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          q_push;
  logic [31:0]   t_rdata;
  fetch_entry_t  q_wdata;
  fetch_entry_t  q_rdata;

  assign used   = {1'b0, q_count}
                + {1'b0, outstanding};
  assign credit = used < (CW+1)'(QDEPTH);

  assign mis = MIS_EN
            && (pc_in[1:0] != 2'b00);

  assign imem_req_addr = MIS_EN ? pc_in
                       : {pc_in[31:2], 2'b00};

  assign imem_req_valid = rst
                       && !redirect_valid
                       && credit && !mis;

  assign req_fire = imem_req_valid
                 && imem_req_ready;

  assign exc_push = rst && mis
                 && !redirect_valid
                 && credit
                 && (outstanding == '0);

  assign stall_out = !rst
                  || (!(req_fire || exc_push)
                      && !redirect_valid);

  assign rsp_ret  = imem_rsp_valid
                 && (outstanding != '0);
  assign rsp_drop = rsp_ret
                 && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid
                 && (drop_cnt == '0)
                 && (t_count != '0);

  assign q_push = (rsp_keep && !redirect_valid)
               || exc_push;

  assign dec_valid = q_count != '0;
  assign dec_fire  = dec_valid && dec_ready;

  assign dec_instr = dec_valid ? q_rdata.instr : '0;
  assign dec_pc    = dec_valid ? q_rdata.pc : '0;
  assign dec_exc   = MIS_EN && dec_valid
                  && q_rdata.exc;

  // Build queue entry from a response or an exception.
  always_comb begin
    q_wdata     = '0;
    q_wdata.pc  = pc_in;
    q_wdata.exc = 1'b1;
    if (rsp_keep) begin
      q_wdata.instr = imem_rsp_data;
      q_wdata.pc    = t_rdata;
      q_wdata.exc   = 1'b0;
    end
  end

  // In-flight and to-be-discarded response counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding
                   + CW'(req_fire)
                   - CW'(rsp_ret);
      if (redirect_valid)
        drop_cnt <= outstanding - CW'(rsp_ret);
      else if (rsp_drop)
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

  ifetch_fifo #(
    .W     (32),
    .DEPTH (QDEPTH)
  ) u_tag (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .push  (req_fire),
    .wdata (pc_in),
    .pop   (rsp_keep),
    .rdata (t_rdata),
    .count (t_count)
  );

  ifetch_fifo #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (dec_fire),
    .rdata (q_rdata),
    .count (q_count)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl with a PC register and memory model.
// Decode stream = accepted fetches since last redirect, in order.
module tb_ifetch_ctrl;
  import aquila_pkg::*;

  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        stall_out;
  logic        redirect_valid = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_exc;

  ifetch_ctrl #(.QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .stall_out      (stall_out),
    .redirect_valid (redirect_valid),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_exc        (dec_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t  sb[$];
  mreq_t mem_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int dead = 0;
  int fire_cnt = 0;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;

  logic [31:0] pc_nxt = RESET_PC;
  logic [31:0] rst_pc = RESET_PC;
  logic [31:0] tgt = '0;
  bit nostall = 0;
  bit prev_redir = 0;
  bit prev_hold = 0;

  function automatic logic [31:0] memf(
    logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13;
  endfunction

  task automatic chkw(string nm,
    logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic chkb(string nm,
    logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b",
               nm, act, exp);
    end
  endtask

  // Monitor: check outputs, then advance the reference model.
  always @(negedge clk) begin : mon
    bit   fire;
    bit   dfire;
    bit   mis;
    bit   erv;
    int   due;
    exp_t e;
    if (!rst) begin
      chkb("rst_req_valid", imem_req_valid, 1'b0);
      chkb("rst_dec_valid", dec_valid, 1'b0);
      chkb("rst_stall", stall_out, 1'b1);
      sb.delete();
      dead = 0;
      pc_nxt = rst_pc;
      prev_redir = 0;
      prev_hold = 0;
    end else begin
      fire  = imem_req_valid && imem_req_ready;
      dfire = dec_valid && dec_ready;
      mis   = pc_in[1:0] != 2'b00;
      erv   = !redirect_valid
           && (sb.size() + dead < QDEPTH);
`ifdef IFETCH_MISALIGN_EN
      erv = erv && !mis;
      if (!mis)
        chkb("stall", stall_out,
             !fire && !redirect_valid);
      if (imem_req_valid)
        chkw("req_addr", imem_req_addr, pc_in);
`else
      chkb("stall", stall_out,
           !fire && !redirect_valid);
      if (imem_req_valid)
        chkw("req_addr", imem_req_addr,
             {pc_in[31:2], 2'b00});
`endif
      chkb("req_valid", imem_req_valid, erv);
      if (nostall)
        chkb("no_stall", stall_out, 1'b0);
      if (prev_redir)
        chkb("empty_after_redirect",
             dec_valid, 1'b0);
      if (prev_hold)
        chkb("head_held", dec_valid, 1'b1);
      if (sb.size() == 0)
        chkb("dec_valid_when_empty",
             dec_valid, 1'b0);
      if (dfire && sb.size() != 0) begin
        e = sb.pop_front();
        chkw("dec_pc", dec_pc, e.pc);
        chkw("dec_instr", dec_instr, e.instr);
        chkb("dec_exc", dec_exc, e.exc);
      end
      if (imem_rsp_valid && dead > 0)
        dead--;
      if (redirect_valid) begin
        sb.delete();
        dead = mem_q.size();
      end
      if (fire) begin
        sb.push_back('{pc: pc_in,
          instr: memf({pc_in[31:2], 2'b00}),
          exc: 1'b0});
        due = cyc + int'($urandom_range(
                lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr:
          {pc_in[31:2], 2'b00}, due: due});
        fire_cnt++;
      end
`ifdef IFETCH_MISALIGN_EN
      if (mis && !stall_out && !redirect_valid)
        sb.push_back('{pc: pc_in,
          instr: 32'h0, exc: 1'b1});
`endif
      if (redirect_valid) pc_nxt = tgt;
      else if (!stall_out) pc_nxt = pc_in + 4;
      else pc_nxt = pc_in;
      prev_redir = redirect_valid;
      prev_hold = dec_valid && !dec_ready
               && !redirect_valid;
    end
  end

  // One cycle of stimulus; memory answers in order when due.
  task automatic step(int pr, int pd,
    int lmin, int lmax, bit rd,
    logic [31:0] t);
    @(posedge clk);
    #1;
    cyc++;
    pc_in = pc_nxt;
    imem_req_ready = $urandom_range(99) < pr;
    dec_ready = $urandom_range(99) < pd;
    redirect_valid = rd && rst;
    tgt = t;
    lat_min = lmin;
    lat_max = lmax;
    if (rst && mem_q.size() != 0
        && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = memf(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0
            || mem_q.size() != 0
            || dead != 0) && n < 60) begin
      step(0, 100, 1, 1, 0, 0);
      n++;
    end
    chkb("drain_done", n < 60, 1'b1);
    step(0, 100, 1, 1, 0, 0);
    step(0, 100, 1, 1, 0, 0);
  endtask

  task automatic rst_checks();
    chkb("rst_dec_valid_now", dec_valid, 1'b0);
    chkb("rst_req_valid_now", imem_req_valid, 1'b0);
    chkb("rst_stall_now", stall_out, 1'b1);
    chkw("rst_dec_instr", dec_instr, 32'h0);
    chkw("rst_dec_pc", dec_pc, 32'h0);
    chkb("rst_dec_exc", dec_exc, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pr[3];
    int pd[3];
    int lm[3];
    int prd[3];
    pr  = '{80, 50, 100};
    pd  = '{70, 30, 100};
    lm  = '{3, 4, 2};
    prd = '{5, 10, 3};

    #1;
    rst_checks();
    repeat (3) step(0, 0, 1, 1, 0, 0);
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    nostall = 1;
    rst = 1'b1;
    repeat (20) step(100, 100, 1, 1, 0, 0);
    nostall = 0;

    drain();
    fire_cnt = 0;
    repeat (10) step(100, 0, 1, 1, 0, 0);
    chkw("credit_fires", fire_cnt, QDEPTH);
    step(100, 100, 1, 1, 0, 0);
    repeat (4) step(100, 0, 1, 1, 0, 0);

    drain();
    repeat (2) step(100, 100, 3, 3, 0, 0);
    step(0, 100, 3, 3, 1, 32'h100);
    repeat (12) step(100, 100, 1, 1, 0, 0);

    step(0, 100, 1, 1, 1, 32'h100);
    repeat (6) step(100, 100, 1, 1, 0, 0);

    step(100, 100, 1, 1, 1, 32'h102);
    repeat (8) step(100, 100, 1, 1, 0, 0);
    step(100, 100, 1, 1, 1, 32'h200);

    for (int ph = 0; ph < 3; ph++) begin
      repeat (300) begin
        step(pr[ph], pd[ph], 1, lm[ph],
             $urandom_range(99) < prd[ph],
             $urandom_range(1023) << 2);
      end
    end

    drain();
    repeat (5) step(100, 0, 1, 1, 0, 0);
    rst = 1'b0;
    rst_pc = 32'h300;
    mem_q.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    rst_checks();
    repeat (2) step(0, 0, 1, 1, 0, 0);
    imem_req_ready = 1'b0;
    dec_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEADBEEF;
    rst = 1'b1;
    repeat (20) step(100, 100, 1, 2, 0, 0);

    drain();
    chkb("final_idle", dec_valid, 1'b0);
    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
